// File: rtl/data_collect_packer.sv
// Packs bytes arriving on a level-style data_ready into memory words.
// Writes NUM_WORDS words from BASE_ADDR upward, then raises finish.
module data_collect_packer #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_W         = 14,
    parameter int NUM_WORDS      = 16,
    parameter int BASE_ADDR      = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BYTE_W-1:0]                  data_input,
    input  logic                               data_ready,
    input  logic                               restart,
    output logic                               MEM_write_enable,
    output logic [ADDR_W-1:0]                  MEM_write_addr,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]   MEM_write_data,
    output logic                               finish,
    output logic                               overrun,
    output logic [ADDR_W:0]                    word_count
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic {COLLECT, DONE} state_t;

    state_t              state_q;
    logic                dataReady_q;
    logic [IDX_W-1:0]    byteIdx_q;
    logic [WORD_W-1:0]   pack_q;
    logic [WORD_W-1:0]   pack_d;
    logic                writeEnable_q;
    logic [ADDR_W-1:0]   writeAddr_q;
    logic [ADDR_W-1:0]   writeAddr_d;
    logic [WORD_W-1:0]   writeData_q;
    logic                finish_q;
    logic                overrun_q;
    logic [ADDR_W:0]     wordCount_q;
    logic                byteEvt;
    logic                lastByte;

    // dataReady_q resets high so a level already asserted at reset release is ignored.
    assign byteEvt     = data_ready & ~dataReady_q;
    assign lastByte    = (byteIdx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign writeAddr_d = ADDR_W'(BASE_ADDR) + wordCount_q[ADDR_W-1:0];

    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (byteIdx_q == IDX_W'(k)) pack_d[k*BYTE_W +: BYTE_W] = data_input;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            dataReady_q   <= 1'b1;
            byteIdx_q     <= '0;
            pack_q        <= '0;
            writeEnable_q <= 1'b0;
            writeAddr_q   <= ADDR_W'(BASE_ADDR);
            writeData_q   <= '0;
            finish_q      <= 1'b0;
            overrun_q     <= 1'b0;
            wordCount_q   <= '0;
        end else begin
            dataReady_q   <= data_ready;
            writeEnable_q <= 1'b0;
            // restart beats a simultaneous byte; an already-registered strobe still goes out.
            if (restart) begin
                state_q     <= COLLECT;
                byteIdx_q   <= '0;
                pack_q      <= '0;
                writeAddr_q <= ADDR_W'(BASE_ADDR);
                finish_q    <= 1'b0;
                overrun_q   <= 1'b0;
                wordCount_q <= '0;
            end else if (byteEvt) begin
                if (state_q == COLLECT) begin
                    if (lastByte) begin
                        writeEnable_q <= 1'b1;
                        writeData_q   <= pack_d;
                        writeAddr_q   <= writeAddr_d;
                        wordCount_q   <= wordCount_q + 1'b1;
                        byteIdx_q     <= '0;
                        pack_q        <= '0;
                        if (wordCount_q == (ADDR_W+1)'(NUM_WORDS - 1)) begin
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end
                    end else begin
                        pack_q    <= pack_d;
                        byteIdx_q <= byteIdx_q + 1'b1;
                    end
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign MEM_write_enable = writeEnable_q;
    assign MEM_write_addr   = writeAddr_q;
    assign MEM_write_data   = writeData_q;
    assign finish           = finish_q;
    assign overrun          = overrun_q;
    assign word_count       = wordCount_q;

endmodule

// File: tb/tb_data_collect_packer.sv
// Directed bench: instance A uses 2 bytes/word and 4 words; instance B uses
// 1 byte/word, 3 words, base 0x100.
module tb_data_collect_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dataA = '0;
    logic        drA = 1'b0;
    logic        restartA = 1'b0;
    logic        weA;
    logic [13:0] addrA;
    logic [15:0] wdataA;
    logic        finishA;
    logic        overrunA;
    logic [14:0] wcA;

    logic [7:0]  dataB = '0;
    logic        drB = 1'b1;
    logic        restartB = 1'b0;
    logic        weB;
    logic [13:0] addrB;
    logic [7:0]  wdataB;
    logic        finishB;
    logic        overrunB;
    logic [14:0] wcB;

    int checks = 0;
    int failures = 0;
    int strobesB = 0;

    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    logic [31:0] logFin[$];

    always #5 clk = ~clk;

    data_collect_packer #(
        .BYTE_W(8), .BYTES_PER_WORD(2), .ADDR_W(14), .NUM_WORDS(4), .BASE_ADDR(0)
    ) dutA (
        .clk(clk), .rst(rst), .data_input(dataA), .data_ready(drA), .restart(restartA),
        .MEM_write_enable(weA), .MEM_write_addr(addrA), .MEM_write_data(wdataA),
        .finish(finishA), .overrun(overrunA), .word_count(wcA)
    );

    data_collect_packer #(
        .BYTE_W(8), .BYTES_PER_WORD(1), .ADDR_W(14), .NUM_WORDS(3), .BASE_ADDR('h100)
    ) dutB (
        .clk(clk), .rst(rst), .data_input(dataB), .data_ready(drB), .restart(restartB),
        .MEM_write_enable(weB), .MEM_write_addr(addrB), .MEM_write_data(wdataB),
        .finish(finishB), .overrun(overrunB), .word_count(wcB)
    );

    // Record every strobe from A, together with finish as seen in that cycle.
    always @(negedge clk) begin
        if (weA) begin
            logAddr.push_back(32'(addrA));
            logData.push_back(32'(wdataA));
            logFin.push_back(32'(finishA));
        end
        if (weB) strobesB = strobesB + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One data_ready pulse on instance A, followed by a low cycle.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        dataA = b;
        drA = 1'b1;
        @(posedge clk); #1;
        drA = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulseRestart();
        @(posedge clk); #1;
        restartA = 1'b1;
        @(posedge clk); #1;
        restartA = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
        logFin.delete();
    endtask

    // Instance B byte with strobe-latency check: idle before the edge, strobe right after it.
    task automatic sendByteB(input logic [7:0] b, input logic [13:0] expAddr,
                             input logic expFinish);
        @(posedge clk); #1;
        dataB = b;
        drB = 1'b1;
        @(negedge clk);
        checkOutput("B we before edge", 32'(weB), 0);
        @(negedge clk);
        checkOutput("B we after edge", 32'(weB), 1);
        checkOutput("B addr", 32'(addrB), 32'(expAddr));
        checkOutput("B data", 32'(wdataB), 32'(b));
        checkOutput("B finish", 32'(finishB), 32'(expFinish));
        @(posedge clk); #1;
        drB = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset we", 32'(weA), 0);
        checkOutput("reset addr", 32'(addrA), 0);
        checkOutput("reset data", 32'(wdataA), 0);
        checkOutput("reset finish", 32'(finishA), 0);
        checkOutput("reset overrun", 32'(overrunA), 0);
        checkOutput("reset word_count", 32'(wcA), 0);
        checkOutput("reset B addr", 32'(addrB), 'h100);

        // B: data_ready held through reset release must not capture.
        repeat (5) @(posedge clk);
        #1;
        checkOutput("B held-level strobes", 32'(strobesB), 0);
        checkOutput("B held-level count", 32'(wcB), 0);
        drB = 1'b0;
        @(posedge clk); #1;
        sendByteB(8'hA0, 14'h100, 1'b0);
        sendByteB(8'hA1, 14'h101, 1'b0);
        sendByteB(8'hA2, 14'h102, 1'b1);
        checkOutput("B strobes total", 32'(strobesB), 3);
        checkOutput("B word_count", 32'(wcB), 3);

        // Single word.
        clearLog();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("t1 strobes", 32'(logData.size()), 1);
        checkOutput("t1 addr", logAddr[0], 0);
        checkOutput("t1 data", logData[0], 'h2211);
        checkOutput("t1 word_count", 32'(wcA), 1);

        // Full run to finish.
        pulseRestart();
        checkOutput("restart word_count", 32'(wcA), 0);
        clearLog();
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        checkOutput("t2 strobes", 32'(logData.size()), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2 addr", logAddr[i], 32'(i));
            checkOutput("t2 data", logData[i], 32'(((2*i+2) << 8) | (2*i+1)));
        end
        checkOutput("t2 finish low on 3rd strobe", logFin[2], 0);
        checkOutput("t2 finish with 4th strobe", logFin[3], 1);
        checkOutput("t2 overrun", 32'(overrunA), 0);
        checkOutput("t2 word_count", 32'(wcA), 4);

        // Bytes after finish are dropped and flag overrun.
        applyStimulus(8'hE1);
        applyStimulus(8'hE2);
        checkOutput("t4 no strobe", 32'(logData.size()), 4);
        checkOutput("t4 word_count", 32'(wcA), 4);
        checkOutput("t4 overrun", 32'(overrunA), 1);
        checkOutput("t4 finish held", 32'(finishA), 1);
        pulseRestart();
        checkOutput("t4 finish cleared", 32'(finishA), 0);
        checkOutput("t4 overrun cleared", 32'(overrunA), 0);
        clearLog();
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        checkOutput("t4 rearm strobes", 32'(logData.size()), 1);
        checkOutput("t4 rearm addr", logAddr[0], 0);
        checkOutput("t4 rearm data", logData[0], 'h4433);

        // Long level counts as one byte.
        pulseRestart();
        clearLog();
        @(posedge clk); #1;
        dataA = 8'hAA;
        drA = 1'b1;
        repeat (20) @(posedge clk);
        #1 drA = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'hBB);
        checkOutput("t3 strobes", 32'(logData.size()), 1);
        checkOutput("t3 data", logData[0], 'hBBAA);
        checkOutput("t3 word_count", 32'(wcA), 1);

        // Partial word discarded by restart.
        pulseRestart();
        clearLog();
        applyStimulus(8'h55);
        pulseRestart();
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        checkOutput("t5 strobes", 32'(logData.size()), 1);
        checkOutput("t5 addr", logAddr[0], 0);
        checkOutput("t5 data", logData[0], 'h7766);

        // Partial word discarded by rst.
        pulseRestart();
        clearLog();
        applyStimulus(8'h55);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5r no strobe in reset", 32'(logData.size()), 0);
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        checkOutput("t5r strobes", 32'(logData.size()), 1);
        checkOutput("t5r addr", logAddr[0], 0);
        checkOutput("t5r data", logData[0], 'h7766);

        // restart coincident with a byte edge drops the byte.
        pulseRestart();
        clearLog();
        @(posedge clk); #1;
        dataA = 8'h99;
        drA = 1'b1;
        restartA = 1'b1;
        @(posedge clk); #1;
        restartA = 1'b0;
        drA = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkOutput("restart+byte strobes", 32'(logData.size()), 1);
        checkOutput("restart+byte data", logData[0], 'h3412);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
